// File: rtl/vga_text_console.sv
// vga_text_console: 80x30 character display for 640x480@60 VGA on the pixel clock.
// Stage 0 counters -> stage 1 text buffer read + glyph coordinates -> stage 2 pixel/sync register.
module vga_text_console #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        cursor_en,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic [7:0]  ascii_code,
  output logic [3:0]  font_row,
  output logic [2:0]  font_col,
  input  logic        font_pixel,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);
  localparam logic [11:0] CELLS     = 12'd2400;

  // Counters and blink state
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [5:0] frame_q, frame_d;
  logic       blink_q, blink_d;

  // Stage 1 registers
  logic       rd_valid_q, rd_valid_d;
  logic [3:0] font_row_q, font_row_d;
  logic [2:0] font_col_q, font_col_d;
  logic       active1_q, active1_d;
  logic       hsync1_q, hsync1_d;
  logic       vsync1_q, vsync1_d;
  logic       hit1_q, hit1_d;

  // Stage 2 registers
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [3:0] rgb_q, rgb_d;

  logic       cursor_on;

  // Text buffer; cells hold the code XOR 0x20 so a zero-initialised array reads back as spaces
  logic [7:0]  mem [0:2399];
  logic [7:0]  rd_data_q;
  logic [6:0]  cell_col;
  logic [5:0]  cell_row;
  logic [11:0] rd_addr;
  logic [11:0] rd_index;

  assign cell_col = h_cnt_q[9:3];
  assign cell_row = v_cnt_q[9:4];
  assign rd_addr  = {cell_row, 6'd0} + {2'd0, cell_row, 4'd0} + {5'd0, cell_col};
  assign rd_index = (rd_addr < CELLS) ? rd_addr : 12'd0;

  // Host write port and synchronous read-before-write buffer read, independent of reset
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < CELLS)) begin
      mem[wr_addr] <= wr_data ^ 8'h20;
    end
    rd_data_q <= mem[rd_index];
  end

  // Next-state logic for counters, blink and both pipeline stages
  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    frame_d = frame_q;
    blink_d = blink_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = 10'd0;
        if (frame_q == BLINK_LAST) begin
          frame_d = 6'd0;
          blink_d = ~blink_q;
        end else begin
          frame_d = frame_q + 6'd1;
        end
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end

    rd_valid_d = 1'b1;
    font_row_d = v_cnt_q[3:0];
    font_col_d = h_cnt_q[2:0];
    active1_d  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hsync1_d   = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
    vsync1_d   = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
    hit1_d     = (cursor_x < 7'd80) && (cursor_y < 5'd30) &&
                 (cell_col == cursor_x) && (cell_row == {1'b0, cursor_y});

    cursor_on  = cursor_en && blink_q && hit1_q && (font_row_q >= 4'd14);
    rgb_d      = (active1_q && (font_pixel || cursor_on)) ? 4'hF : 4'h0;
    hsync_d    = hsync1_q;
    vsync_d    = vsync1_q;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q    <= 10'd0;
      v_cnt_q    <= 10'd0;
      frame_q    <= 6'd0;
      blink_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      font_row_q <= 4'd0;
      font_col_q <= 3'd0;
      active1_q  <= 1'b0;
      hsync1_q   <= 1'b1;
      vsync1_q   <= 1'b1;
      hit1_q     <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= 4'h0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      rd_valid_q <= rd_valid_d;
      font_row_q <= font_row_d;
      font_col_q <= font_col_d;
      active1_q  <= active1_d;
      hsync1_q   <= hsync1_d;
      vsync1_q   <= vsync1_d;
      hit1_q     <= hit1_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
    end
  end

  assign ascii_code = rd_valid_q ? (rd_data_q ^ 8'h20) : 8'h00;
  assign font_row   = font_row_q;
  assign font_col   = font_col_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign vga_r      = rgb_q;
  assign vga_g      = rgb_q;
  assign vga_b      = rgb_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: a full-size instance for horizontal timing and a
// reduced-timing instance (80x70 clock frame, 2-frame blink) for buffer, cursor and reset behaviour.
module tb_vga_text_console;

  localparam int SEL_HS   = 0;
  localparam int SEL_VS   = 1;
  localparam int SEL_RGB  = 2;
  localparam int SEL_ASC  = 3;
  localparam int SEL_FR   = 4;
  localparam int SEL_FC   = 5;
  localparam int SEL_FHS  = 6;
  localparam int SEL_FVS  = 7;
  localparam int SEL_FRGB = 8;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [11:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cursor_en;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  logic [7:0]  s_ascii;
  logic [3:0]  s_frow;
  logic [2:0]  s_fcol;
  logic        s_font_pixel;
  logic        s_hsync, s_vsync;
  logic [3:0]  s_r, s_g, s_b;

  logic [7:0]  f_ascii;
  logic [3:0]  f_frow;
  logic [2:0]  f_fcol;
  logic        f_font_pixel;
  logic        f_hsync, f_vsync;
  logic [3:0]  f_r, f_g, f_b;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];

  // Font model: 'A' is a bar in glyph column 0, 'B' is a bar in glyph row 1, all else blank
  function automatic logic font_fn(input logic [7:0] a, input logic [3:0] r, input logic [2:0] c);
    if (a == 8'h41) return (c == 3'd0);
    if (a == 8'h42) return (r == 4'd1);
    return 1'b0;
  endfunction

  assign s_font_pixel = font_fn(s_ascii, s_frow, s_fcol);
  assign f_font_pixel = font_fn(f_ascii, f_frow, f_fcol);

  vga_text_console #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(64), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .BLINK_FRAMES(2)
  ) dut_small (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .ascii_code(s_ascii), .font_row(s_frow), .font_col(s_fcol), .font_pixel(s_font_pixel),
    .hsync(s_hsync), .vsync(s_vsync), .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
  );

  vga_text_console dut_full (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .ascii_code(f_ascii), .font_row(f_frow), .font_col(f_fcol), .font_pixel(f_font_pixel),
    .hsync(f_hsync), .vsync(f_vsync), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b)
  );

  // 25 MHz pixel clock
  always #20 clk = ~clk;

  // Clock edges since the last reset release; output of counter position p is valid at cyc p+2
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [11:0] getActual(input int sel);
    case (sel)
      SEL_HS:   return {11'd0, s_hsync};
      SEL_VS:   return {11'd0, s_vsync};
      SEL_RGB:  return {s_r, s_g, s_b};
      SEL_ASC:  return {4'd0, s_ascii};
      SEL_FR:   return {8'd0, s_frow};
      SEL_FC:   return {9'd0, s_fcol};
      SEL_FHS:  return {11'd0, f_hsync};
      SEL_FVS:  return {11'd0, f_vsync};
      SEL_FRGB: return {f_r, f_g, f_b};
      default:  return 12'hXXX;
    endcase
  endfunction

  // Insert an expectation keeping the scoreboard ordered by cycle
  task automatic pushExp(input int unsigned c, input int sel, input logic [11:0] v, input string n);
    exp_t e;
    int   i;
    e.cyc = c; e.sel = sel; e.val = v; e.name = n;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [11:0] act;
    act = getActual(e.sel);
    vectors++;
    if (act !== e.val) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", e.name, e.cyc, act, e.val);
    end
  endtask

  // Presents one host write at the current negedge; it lands on the next rising edge
  task automatic applyStimulus(input logic [11:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic waitCyc(input int unsigned n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait_cycle: reached %0d, expected %0d", cyc, n);
    end
  endtask

  task automatic pushResetChecks();
    pushExp(0, SEL_HS,   12'h001, "rst_hsync");
    pushExp(0, SEL_VS,   12'h001, "rst_vsync");
    pushExp(0, SEL_RGB,  12'h000, "rst_rgb");
    pushExp(0, SEL_ASC,  12'h000, "rst_ascii");
    pushExp(0, SEL_FR,   12'h000, "rst_font_row");
    pushExp(0, SEL_FC,   12'h000, "rst_font_col");
    pushExp(0, SEL_FHS,  12'h001, "rst_full_hsync");
    pushExp(0, SEL_FVS,  12'h001, "rst_full_vsync");
    pushExp(0, SEL_FRGB, 12'h000, "rst_full_rgb");
  endtask

  // Monitor: on each falling edge retire every expectation due at this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL %s: due at cycle %0d, passed at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  // Stimulus
  initial begin
    int guard;
    wr_en = 1'b0; wr_addr = 12'd0; wr_data = 8'd0;
    cursor_en = 1'b1; cursor_x = 7'd1; cursor_y = 5'd2;
    #1 resetn = 1'b0;
    pushResetChecks();
    repeat (2) @(negedge clk);

    applyStimulus(12'd0,    8'h41);
    applyStimulus(12'd8,    8'h41);
    applyStimulus(12'd247,  8'h42);
    applyStimulus(12'd320,  8'h41);
    applyStimulus(12'd2400, 8'h42);

    pushExp(1,     SEL_ASC, 12'h041, "first_ascii");
    pushExp(1,     SEL_FR,  12'h000, "first_font_row");
    pushExp(1,     SEL_FC,  12'h000, "first_font_col");
    pushExp(2,     SEL_RGB, 12'hFFF, "first_pixel_on");
    pushExp(3,     SEL_RGB, 12'h000, "second_pixel_off");
    pushExp(65,    SEL_ASC, 12'h041, "hblank_read_cell8");
    pushExp(66,    SEL_RGB, 12'h000, "hblank_gated");
    pushExp(69,    SEL_HS,  12'h001, "hsync_before");
    pushExp(70,    SEL_HS,  12'h000, "hsync_fall");
    pushExp(77,    SEL_HS,  12'h000, "hsync_last_low");
    pushExp(78,    SEL_HS,  12'h001, "hsync_rise");
    pushExp(408,   SEL_FR,  12'h005, "font_row_5");
    pushExp(408,   SEL_FC,  12'h007, "font_col_7");
    pushExp(657,   SEL_FHS, 12'h001, "full_hsync_before");
    pushExp(658,   SEL_FHS, 12'h000, "full_hsync_fall");
    pushExp(753,   SEL_FHS, 12'h000, "full_hsync_last_low");
    pushExp(754,   SEL_FHS, 12'h001, "full_hsync_rise");
    pushExp(1457,  SEL_FHS, 12'h001, "full_hsync2_before");
    pushExp(1458,  SEL_FHS, 12'h000, "full_hsync2_fall");
    pushExp(1553,  SEL_FHS, 12'h000, "full_hsync2_last_low");
    pushExp(1554,  SEL_FHS, 12'h001, "full_hsync2_rise");
    pushExp(3690,  SEL_RGB, 12'h000, "cursor_blink_off_f0");
    pushExp(3977,  SEL_ASC, 12'h042, "cell247_ascii");
    pushExp(3978,  SEL_RGB, 12'hFFF, "cell247_row1_on");
    pushExp(4058,  SEL_RGB, 12'h000, "cell247_row2_off");
    pushExp(5122,  SEL_RGB, 12'h000, "vblank_gated");
    pushExp(5281,  SEL_VS,  12'h001, "vsync_before");
    pushExp(5282,  SEL_VS,  12'h000, "vsync_fall");
    pushExp(5441,  SEL_VS,  12'h000, "vsync_last_low");
    pushExp(5442,  SEL_VS,  12'h001, "vsync_rise");
    pushExp(5602,  SEL_RGB, 12'hFFF, "frame1_first_pixel");
    pushExp(5609,  SEL_ASC, 12'h020, "rbw_old_code");
    pushExp(5610,  SEL_RGB, 12'h000, "rbw_old_pixel");
    pushExp(11209, SEL_ASC, 12'h041, "rbw_new_code");
    pushExp(11210, SEL_RGB, 12'hFFF, "rbw_new_pixel");
    pushExp(14810, SEL_RGB, 12'h000, "cursor_row13_off");
    pushExp(14890, SEL_RGB, 12'hFFF, "cursor_f2_on");
    pushExp(14977, SEL_RGB, 12'hFFF, "cursor_f2_last_px");
    pushExp(14978, SEL_RGB, 12'h000, "cursor_f2_past_cell");
    pushExp(20490, SEL_RGB, 12'hFFF, "cursor_f3_on");
    pushExp(26090, SEL_RGB, 12'h000, "cursor_f4_off");
    pushExp(37290, SEL_RGB, 12'hFFF, "cursor_f6_on");
    pushExp(42890, SEL_RGB, 12'h000, "cursor_x80_hidden");
    pushExp(45202, SEL_RGB, 12'hFFF, "pre_reset_pixel");

    @(negedge clk);
    resetn = 1'b1;

    waitCyc(5608);
    applyStimulus(12'd1, 8'h41);

    waitCyc(39300);
    cursor_x = 7'd80;
    cursor_y = 5'd0;

    waitCyc(45202);
    #2 resetn = 1'b0;
    #1 pushResetChecks();
    repeat (3) @(negedge clk);
    pushExp(1,   SEL_ASC, 12'h041, "restart_ascii");
    pushExp(1,   SEL_FR,  12'h000, "restart_font_row");
    pushExp(1,   SEL_FC,  12'h000, "restart_font_col");
    pushExp(2,   SEL_RGB, 12'hFFF, "restart_pixel_on");
    pushExp(70,  SEL_HS,  12'h000, "restart_hsync_fall");
    pushExp(658, SEL_FHS, 12'h000, "restart_full_hsync_fall");
    resetn = 1'b1;

    guard = 0;
    while (sb.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: never reached cycle %0d", e.name, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
